// File: rtl/regfile_multiport.sv
// Decode-stage register file: one write port, two registered read ports,
// optional hardwired-zero entry 0, write-to-read bypass and a clear sweep.
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic              clr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy
);

  // state | meaning
  // ------+----------------------------------------------------
  // IDLE  | normal access; we/re/clr honoured
  // CLEAR | one entry zeroed per cycle at ptr; accesses blocked
  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_load;
  logic              wr_live;
  logic [DATA_W-1:0] rd_a_d, rd_b_d;

  // A write to entry 0 with ZERO_REG set is dropped entirely, including bypass.
  assign wr_live = we && !(ZERO_REG && (waddr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (clr) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
      S_CLEAR: begin
        ptr_d = ptr_q + PTR_ONE;
        if (ptr_q == PTR_LAST) state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    rd_load   = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_we  = wr_live;
        rd_load = re;
      end
      S_CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
      end
    endcase
  end

  // Array is deliberately not reset; the sweep zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    rd_a_d = mem[raddr_a];
    if (ZERO_REG && (raddr_a == '0))
      rd_a_d = '0;
    else if (BYPASS && wr_live && (waddr == raddr_a))
      rd_a_d = wdata;
  end

  always_comb begin
    rd_b_d = mem[raddr_b];
    if (ZERO_REG && (raddr_b == '0))
      rd_b_d = '0;
    else if (BYPASS && wr_live && (waddr == raddr_b))
      rd_b_d = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (rd_load) begin
      rdata_a <= rd_a_d;
      rdata_b <= rd_b_d;
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench: default instance plus a ZERO_REG=0/BYPASS=0 instance
// driven in parallel; expected read data is queued and checked by a monitor.
module tb_regfile_multiport;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0, re = 1'b0, clr = 1'b0;
  logic [AW-1:0] waddr = '0, raddr_a = '0, raddr_b = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata_a, rdata_b, rdata_a_alt, rdata_b_alt;
  logic          busy, busy_alt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] a_alt;
    logic [DW-1:0] b_alt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic rd_issue = 1'b0;
  logic launched = 1'b0;
  int   rd_id = 0;

  regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .clr(clr),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy)
  );

  regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_alt (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .clr(clr),
    .rdata_a(rdata_a_alt), .rdata_b(rdata_b_alt), .busy(busy_alt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [DW-1:0] aa, input logic [DW-1:0] ba);
    exp_t e;
    e.a = a; e.b = b; e.a_alt = aa; e.b_alt = ba;
    return e;
  endfunction

  // Monitor: every edge the stimulus flagged is compared one half-cycle later.
  always @(posedge clk) launched <= rd_issue;

  always @(negedge clk) begin
    if (launched) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got no expectation, required one");
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("rd%0d_a", rd_id), rdata_a, mon_e.a);
        chk($sformatf("rd%0d_b", rd_id), rdata_b, mon_e.b);
        chk($sformatf("rd%0d_a_alt", rd_id), rdata_a_alt, mon_e.a_alt);
        chk($sformatf("rd%0d_b_alt", rd_id), rdata_b_alt, mon_e.b_alt);
        rd_id++;
      end
    end
  end

  task automatic op(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                    input logic r, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                    input logic c, input logic chk_en, input exp_t e);
    we = w; waddr = wa; wdata = wd; re = r; raddr_a = ra; raddr_b = rb; clr = c;
    rd_issue = chk_en;
    if (chk_en) exp_q.push_back(e);
    @(negedge clk);
    we = 1'b0; re = 1'b0; clr = 1'b0; rd_issue = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    op(1'b1, a, d, 1'b0, '0, '0, 1'b0, 1'b0, mk('0, '0, '0, '0));
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b, input exp_t e);
    op(1'b0, '0, '0, 1'b1, a, b, 1'b0, 1'b1, e);
  endtask

  task automatic wait_busy(input string name, input int required);
    int n = 0;
    while ((busy || busy_alt) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, DW'(n), DW'(required));
    chk({name, "_busy_eq"}, {31'd0, busy_alt}, {31'd0, busy});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    exp_t hold;

    // Reset state
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_busy_alt", {31'd0, busy_alt}, 32'd1);
    chk("rst_rdata_a", rdata_a, '0);
    chk("rst_rdata_b", rdata_b, '0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_busy("init_sweep_cycles", 32);

    for (int i = 0; i < 32; i++)
      rd(AW'(i), AW'(31 - i), mk('0, '0, '0, '0));

    // Basic write / read
    wr(5'd5, 32'hDEADBEEF);
    wr(5'd31, 32'h12345678);
    rd(5'd5, 5'd31, mk(32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678));

    // Entry 0 hardwired only in the default instance
    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0, mk('0, '0, 32'hFFFFFFFF, 32'hFFFFFFFF));

    // Same-edge write and read of entry 7
    wr(5'd7, 32'h11111111);
    op(1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 5'd7, 1'b0, 1'b1,
       mk(32'h22222222, 32'h22222222, 32'h11111111, 32'h11111111));
    rd(5'd7, 5'd7, mk(32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222));

    // Discarded write to entry 0 must not bypass; alt stores it without bypass
    op(1'b1, 5'd0, 32'hAAAAAAAA, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1,
       mk('0, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF));
    rd(5'd0, 5'd0, mk('0, '0, 32'hAAAAAAAA, 32'hAAAAAAAA));

    // A write with re low leaves rdata alone
    op(1'b1, 5'd5, 32'h55555555, 1'b0, 5'd5, 5'd0, 1'b0, 1'b1,
       mk('0, '0, 32'hAAAAAAAA, 32'hAAAAAAAA));
    rd(5'd5, 5'd0, mk(32'h55555555, '0, 32'h55555555, 32'hAAAAAAAA));

    // clr with a coincident write; accesses during the sweep are ignored
    hold = mk(32'h55555555, '0, 32'h55555555, 32'hAAAAAAAA);
    op(1'b1, 5'd9, 32'h99999999, 1'b0, '0, '0, 1'b1, 1'b0, hold);
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("clr_busy_%0d", k), {31'd0, busy}, 32'd1);
      op(1'b1, AW'(k), 32'hC0DE0000 + DW'(k), 1'b1, AW'(k), AW'(31 - k), 1'b1, 1'b1, hold);
    end
    chk("clr_busy_done", {31'd0, busy}, 32'd0);
    chk("clr_busy_done_alt", {31'd0, busy_alt}, 32'd0);
    for (int i = 0; i < 32; i++)
      rd(AW'(i), AW'((i + 9) % 32), mk('0, '0, '0, '0));

    // Reset during a sweep
    wr(5'd3, 32'h33333333);
    rd(5'd3, 5'd3, mk(32'h33333333, 32'h33333333, 32'h33333333, 32'h33333333));
    op(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, hold);
    repeat (9) @(negedge clk);
    chk("mid_sweep_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd1);
    chk("abort_rdata_a", rdata_a, '0);
    chk("abort_rdata_b", rdata_b, '0);
    chk("abort_rdata_a_alt", rdata_a_alt, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_busy("restart_sweep_cycles", 32);
    rd(5'd3, 5'd31, mk('0, '0, '0, '0));

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", DW'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the single-write / two-read CPU register file.
- Configurable data width and depth, plus:
  - an optional hardwired-zero register 0;
  - optional write-to-read bypass;
  - reads that are independent of write enable;
  - a sequential clear engine that zeroes every entry after reset or on request.
- Sits in the decode stage. Feeds operand buses A/B to the ALU and takes writeback data from the WB stage.

Parameters:
- DATA_W, 32: width of each register and of wdata/rdata.
- ADDR_W, 5: address width. DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1: if 1, entry 0 always reads 0 and writes to it are discarded.
- BYPASS, 1: if 1, a same-edge write to an address being read returns the new data on the read port.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write (destination) register address.
- wdata  in  DATA_W  write data.
- re  in  1  read enable for both read ports.
- raddr_a  in  ADDR_W  source register 1 address.
- raddr_b  in  ADDR_W  source register 2 address.
- clr  in  1  start a full clear sweep (single-cycle pulse; sampled only when idle).
- rdata_a  out  DATA_W  registered read data, port A (BusA).
- rdata_b  out  DATA_W  registered read data, port B (BusB).
- busy  out  1  clear sweep in progress; all accesses are blocked.

Behaviour:

Reset (rst_n low, asynchronous):
- rdata_a = 0, rdata_b = 0, busy = 1, clear pointer = 0, FSM = CLEAR.
- Array contents are not reset directly; the sweep zeroes them.

FSM:
- Two states, IDLE and CLEAR.
- IDLE -> CLEAR when clr = 1 at an edge. busy becomes 1 after that edge and the pointer loads 0.
- In CLEAR, each edge writes 0 to entry[ptr] and increments ptr.
- On the edge that writes entry DEPTH-1, FSM -> IDLE and busy -> 0.
- busy is therefore high for exactly DEPTH cycles after rst_n deassertion, or after the clr edge.

During CLEAR:
- we, re and clr are ignored.
- rdata_a/rdata_b hold their values (0 after reset).

Write path:
- In IDLE, we = 1 at an edge stores wdata into entry[waddr].
- If ZERO_REG = 1 and waddr = 0, the write is discarded.
- we and clr at the same IDLE edge: the write is performed, then the sweep starts and clears it.

Read path (1-cycle latency):
- In IDLE, re = 1 at an edge loads rdata_a <= entry[raddr_a] and rdata_b <= entry[raddr_b]. Values are the contents before that edge's write.
- Each port applies the following independently:
  - If ZERO_REG = 1 and the address is 0, the port loads 0.
  - Else if BYPASS = 1, we = 1 and waddr equals the read address, the port loads wdata.
  - Bypass never applies to a discarded write to entry 0.
- re = 0: both rdata outputs hold. A write alone never changes rdata.
- raddr_a = raddr_b is legal; both ports return the same value.

Widths:
- All addresses are full-range; no out-of-range case exists.
- Data is stored and returned unmodified. No sign extension.

Reset mid-operation:
- rst_n low during CLEAR or IDLE aborts any activity immediately.
- The sweep restarts from entry 0 after release.

Test Plan:
- Release rst_n, hold we = re = clr = 0 -> busy = 1 for exactly 32 cycles, then 0. A read of each of entries 0..31 then returns 0x00000000.
- Write 0xDEADBEEF to entry 5, write 0x12345678 to entry 31. Next cycle re = 1 with raddr_a = 5, raddr_b = 31 -> after one edge rdata_a = 0xDEADBEEF, rdata_b = 0x12345678.
- Write 0xFFFFFFFF to entry 0, then read raddr_a = 0 -> rdata_a = 0 (ZERO_REG = 1). With ZERO_REG = 0 -> rdata_a = 0xFFFFFFFF.
- Entry 7 holds 0x11111111. Same edge: we = 1, waddr = 7, wdata = 0x22222222, re = 1, raddr_a = raddr_b = 7 -> rdata_a = rdata_b = 0x22222222 with BYPASS = 1, or 0x11111111 with BYPASS = 0. Next read returns 0x22222222 either way.
- In IDLE pulse clr, and drive we = 1 / re = 1 during the 32 busy cycles -> writes and reads are ignored and rdata is unchanged. After busy falls, all entries read 0.
- Assert rst_n low at cycle 10 of a clr sweep -> busy = 1 and rdata = 0 immediately. After release, busy stays high a full 32 cycles.
